// File: rtl/nn_result_fifo_if.sv
// Register-window bus between software master and the nn_result_fifo capture stage.
// Single-cycle strobes in, registered read data and one-cycle acknowledge out.
interface nn_result_fifo_if;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wren;
    logic        rden;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;

    modport master (
        output wbs_adr_i,
        output wbs_dat_i,
        output wren,
        output rden,
        input  wbs_dat_o,
        input  wbs_ack_o
    );

    modport slave (
        input  wbs_adr_i,
        input  wbs_dat_i,
        input  wren,
        input  rden,
        output wbs_dat_o,
        output wbs_ack_o
    );
endinterface

// File: rtl/nn_result_fifo.sv
// Captures each neural-network core result with its start-to-ready latency into a
// small FIFO that software drains through a four-register bus window.
module nn_result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter logic [31:0] BASE  = 32'h3000_0100,
    parameter int unsigned LAT_W = 16
) (
    input  logic            clk,
    input  logic            rst_l,
    input  logic [31:0]     nn_result,
    input  logic            nn_ready,
    input  logic            start,
    nn_result_fifo_if.slave wbs,
    output logic            irq
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [31:0]      result;
        logic [LAT_W-1:0] lat;
    } entry_t;

    logic             r_ready_d;
    logic             r_start_d;
    logic             w_ready_rise;
    logic             w_start_rise;
    logic [LAT_W-1:0] r_lat;
    logic             r_running;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_ovf;
    logic             w_ovf_nxt;
    logic             w_do_push;

    logic [31:0]      w_off;
    logic [1:0]       w_idx;
    logic             w_hit;
    logic             w_wr;
    logic             w_rd;
    logic             w_pop;
    logic             w_flush;
    logic             w_clr_ovf;
    logic             w_empty;
    logic             w_full;
    entry_t           w_head;
    logic [31:0]      w_rd_data;
    logic             w_unused;

    // Input history for rise detection
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_ready_d <= 1'b0;
            r_start_d <= 1'b0;
        end else begin
            r_ready_d <= nn_ready;
            r_start_d <= start;
        end
    end

    assign w_ready_rise = nn_ready & ~r_ready_d;
    assign w_start_rise = start & ~r_start_d;

    // Latency counter: starts at 1 on the cycle after start rises, so the value seen
    // in the ready-rise cycle equals the cycle distance between the two rises.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_lat     <= '0;
            r_running <= 1'b0;
        end else begin
            if (w_start_rise) begin
                r_lat     <= LAT_W'(1);
                r_running <= 1'b1;
            end else if (r_running && (r_lat != '1)) begin
                r_lat <= r_lat + LAT_W'(1);
            end
            if (w_ready_rise) begin
                r_running <= 1'b0;
            end
        end
    end

    // Address decode; addresses below BASE wrap to a large offset and miss
    assign w_off     = wbs.wbs_adr_i - BASE;
    assign w_idx     = w_off[3:2];
    assign w_hit     = (wbs.wren | wbs.rden) && (w_off[31:4] == 28'd0) && (w_off[1:0] == 2'b00);
    assign w_wr      = w_hit & wbs.wren;
    assign w_rd      = w_hit & ~wbs.wren;
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_CNT);
    assign w_pop     = w_rd && (w_idx == 2'd0) && !w_empty;
    assign w_flush   = w_wr && (w_idx == 2'd3) && wbs.wbs_dat_i[0];
    assign w_clr_ovf = w_wr && (w_idx == 2'd3) && wbs.wbs_dat_i[1];
    assign w_head    = r_mem[r_rd_ptr];
    assign w_unused  = ^wbs.wbs_dat_i[31:2];

    // FIFO bookkeeping: a pop frees the slot a same-cycle push needs, flush beats push
    always_comb begin
        w_rd_ptr_nxt = r_rd_ptr;
        w_wr_ptr_nxt = r_wr_ptr;
        w_count_nxt  = r_count;
        w_ovf_nxt    = r_ovf;
        w_do_push    = 1'b0;
        if (w_clr_ovf) begin
            w_ovf_nxt = 1'b0;
        end
        if (w_flush) begin
            w_rd_ptr_nxt = '0;
            w_wr_ptr_nxt = '0;
            w_count_nxt  = '0;
        end else begin
            w_do_push = w_ready_rise && (!w_full || w_pop);
            if (w_ready_rise && w_full && !w_pop) begin
                w_ovf_nxt = 1'b1;
            end
            if (w_do_push) begin
                w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_pop) begin
                w_count_nxt = r_count + CNT_W'(1);
            end else if (!w_do_push && w_pop) begin
                w_count_nxt = r_count - CNT_W'(1);
            end
        end
    end

    // Register read mux, sampled before any pop of this cycle
    always_comb begin
        w_rd_data = '0;
        case (w_idx)
            2'd0: if (!w_empty) w_rd_data = w_head.result;
            2'd1: w_rd_data = 32'({5'(r_count), 1'b0, r_ovf, w_full, w_empty});
            2'd2: if (!w_empty) w_rd_data = 32'(w_head.lat);
            default: w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_ovf         <= 1'b0;
            irq           <= 1'b0;
            wbs.wbs_ack_o <= 1'b0;
            wbs.wbs_dat_o <= '0;
        end else begin
            r_rd_ptr      <= w_rd_ptr_nxt;
            r_wr_ptr      <= w_wr_ptr_nxt;
            r_count       <= w_count_nxt;
            r_ovf         <= w_ovf_nxt;
            irq           <= (w_count_nxt != '0);
            wbs.wbs_ack_o <= w_hit;
            wbs.wbs_dat_o <= w_rd ? w_rd_data : '0;
        end
    end

    // Storage array carries no reset; only slots below count are ever read out
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr].result <= nn_result;
            r_mem[r_wr_ptr].lat    <= r_running ? r_lat : '0;
        end
    end
endmodule

// File: doc/nn_result_fifo.md
# nn_result_fifo

Downstream capture stage for the 2-2-1 neural-network core. It samples the 32-bit float result on each rising edge of the core's `ready`, together with a measured start-to-ready latency. Each result/latency pair is stored in a small FIFO. The Wishbone-style register window lets software drain results from a batch of inferences without polling `ready` for every sample.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `BASE`, 32'h3000_0100: byte address of register 0; window is BASE..BASE+0xC.
- `LAT_W`, 16: latency field width.

Ports:
- `clk` in 1: clock.
- `rst_l` in 1: asynchronous, active-low reset.
- `nn_result` in 32: core result; valid while `nn_ready` is high.
- `nn_ready` in 1: core result-valid level.
- `start` in 1: user start level; same signal as the core's `in_valid_user`.
- `wbs_adr_i` in 32: access address.
- `wbs_dat_i` in 32: write data.
- `wren` in 1: write strobe.
- `rden` in 1: read strobe.
- `wbs_dat_o` out 32: read data; valid while `wbs_ack_o` is high, 0 otherwise.
- `wbs_ack_o` out 1: one-cycle acknowledge.
- `irq` out 1: registered, high while the FIFO is non-empty.

## Operation
- Edge detect: `ready_d` and `start_d` are registered copies of the inputs. A rise is `x & ~x_d`.
- Latency counter `lat` (LAT_W bits) and `running` flag:
  - Start rise: `lat`<=1, `running`<=1. A start rise while already running restarts the counter.
  - While running and no start rise: `lat`<=`lat`+1, saturating at all-ones.
  - Ready rise: `running`<=0.
- Push: on a ready rise, write {`nn_result`, `running` ? `lat` : 0} at `wr_ptr`. Net effect: the latency field equals R−S, where S is the first cycle `start` is sampled high and R is the first cycle `nn_ready` is sampled high.
- Pointers: `rd_ptr`, `wr_ptr` are log2(DEPTH) bits and wrap modulo DEPTH. `count` is 0..DEPTH.
- Registers (word offsets):
  - 0x0 DATA (R): head result. A read pops the entry. A read when empty returns 0 and does not pop.
  - 0x4 STATUS (R): [0] empty, [1] full, [2] overflow (sticky), [8:4] count (zero-extended), rest 0.
  - 0x8 LAT (R): head latency, zero-extended; no pop. Returns 0 when empty. Software reads LAT before DATA.
  - 0xC CTRL (W): bit0 flush (pointers and count to 0); bit1 clear overflow. Reads of CTRL return 0.
- Access decode: an access is `wren` or `rden` with `wbs_adr_i` in the window and bits [1:0]=0.
  - `wren` has priority when both strobes are high.
  - Writes to read-only offsets are acknowledged and ignored.
  - Out-of-window or misaligned addresses get no ack.
- Boundary rules:
  - Push while full, no pop in the same cycle: entry dropped, overflow<=1.
  - Push and pop in the same cycle: both performed, count unchanged. This holds even when full; no overflow is flagged.
  - Flush and push in the same cycle: flush wins, push discarded, no overflow.
  - Clear-overflow and a new overflow in the same cycle: overflow stays 1.
  - `nn_ready` held high for multiple cycles: exactly one push.

## Timing
- Reset values: `wbs_dat_o`=0, `wbs_ack_o`=0, `irq`=0. Internally: pointers, count, overflow, `lat`, `running`, `ready_d`, `start_d` all 0.
- Push commits at the clock edge ending cycle R. STATUS and `irq` reflect it from cycle R+1.
- Access in cycle T:
  - `wbs_ack_o` is high for exactly cycle T+1.
  - Read data is registered at the T edge, captured before the pop.
  - Pop and CTRL effects are visible from T+1.
- Back-to-back accesses in consecutive cycles each get their own ack.
- Reset asserted mid-operation: all state clears asynchronously; an ack in flight is dropped.

## Test plan
- Start rise at cycle 10, `nn_ready` rise at cycle 64 with result 32'h3F31_8000 → STATUS count=1, `irq`=1 from cycle 65. LAT read returns 54. DATA read returns 32'h3F31_8000. STATUS then reads empty=1 and `irq`=0.
- Five inferences with DEPTH=4, no reads → count=4, full=1, overflow=1. The first four results drain in order. Write CTRL=0x2 → overflow=0.
- FIFO full; `nn_ready` rise in the same cycle as a DATA read → count stays 4, overflow=0, the new result lands at the tail.
- DATA read when empty → ack next cycle, data 0, count stays 0. Access to BASE+0x10 → no ack.
- `nn_ready` held high for 20 cycles → one push. A ready rise with no prior start → latency field 0. `start` held 70000 cycles before ready → latency 16'hFFFF.
- Two entries queued; write CTRL=0x1 in the same cycle as a ready rise → count=0 and empty=1 from the next cycle. Reset mid-read → ack stays 0.
